// File: rtl/sqrt_seq_ctrl_if.sv
// Handshake and datapath-control bundle for the square-root sequencer.
// master: requester/datapath side (drives start, abort, rem_neg).
// slave:  the sequencer itself (drives strobes, status and iter_idx).
interface sqrt_seq_ctrl_if #(
  parameter int WIDTH = 8
);
  localparam int ITER = WIDTH / 2;
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

  logic          start;
  logic          abort;
  logic          rem_neg;
  logic          busy;
  logic          done;
  logic          ld_en;
  logic          it_en;
  logic          sub_sel;
  logic          q_bit;
  logic          fix_en;
  logic [CW-1:0] iter_idx;

  modport master (
    output start, abort, rem_neg,
    input  busy, done, ld_en, it_en, sub_sel, q_bit, fix_en, iter_idx
  );

  modport slave (
    input  start, abort, rem_neg,
    output busy, done, ld_en, it_en, sub_sel, q_bit, fix_en, iter_idx
  );
endinterface

// File: rtl/sqrt_seq_ctrl.sv
// Sequencing FSM for an iterative non-restoring square-root datapath.
// Produces load / iterate / fix enables, the add-sub select and the quotient
// bit, and a start/busy/done handshake. No arithmetic lives here.
// Every output except q_bit is a flop; each branch of the FSM sets the
// outputs that belong to the state it is moving into, so the strobes are
// aligned with the state register and glitch-free.
module sqrt_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sqrt_seq_ctrl_if.slave         bus
);
  localparam int ITER = WIDTH / 2;
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t        state_reg;
  logic          busy_reg;
  logic          done_reg;
  logic          ld_en_reg;
  logic          it_en_reg;
  logic          sub_sel_reg;
  logic          fix_en_reg;
  logic [CW-1:0] iter_idx_reg;

  // State and registered outputs. Outputs default to their idle/reset values
  // every edge; the branch taken overrides those belonging to the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      ld_en_reg    <= 1'b0;
      it_en_reg    <= 1'b0;
      sub_sel_reg  <= 1'b1;
      fix_en_reg   <= 1'b0;
      iter_idx_reg <= '0;
    end else begin
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      ld_en_reg    <= 1'b0;
      it_en_reg    <= 1'b0;
      sub_sel_reg  <= 1'b1;
      fix_en_reg   <= 1'b0;
      iter_idx_reg <= '0;
      state_reg    <= S_IDLE;

      case (state_reg)
        S_IDLE: begin
          // abort has priority over a simultaneous start
          if (bus.start && !bus.abort) begin
            state_reg <= S_LOAD;
            ld_en_reg <= 1'b1;
            busy_reg  <= 1'b1;
          end
        end

        S_LOAD: begin
          if (!bus.abort) begin
            state_reg    <= S_ITER;
            it_en_reg    <= 1'b1;
            busy_reg     <= 1'b1;
            iter_idx_reg <= CW'(ITER - 1);
            // first iteration always subtracts the trial value
            sub_sel_reg  <= 1'b1;
          end
        end

        S_ITER: begin
          if (!bus.abort) begin
            if (iter_idx_reg == '0) begin
              // a negative final remainder needs one restore step
              if (bus.rem_neg) begin
                state_reg   <= S_FIX;
                fix_en_reg  <= 1'b1;
                busy_reg    <= 1'b1;
                sub_sel_reg <= 1'b0;
              end else begin
                state_reg <= S_DONE;
                done_reg  <= 1'b1;
              end
            end else begin
              state_reg    <= S_ITER;
              it_en_reg    <= 1'b1;
              busy_reg     <= 1'b1;
              iter_idx_reg <= iter_idx_reg - CW'(1);
              // non-restoring: next op adds when remainder went negative
              sub_sel_reg  <= ~bus.rem_neg;
            end
          end
        end

        S_FIX: begin
          if (!bus.abort) begin
            state_reg <= S_DONE;
            done_reg  <= 1'b1;
          end
        end

        S_DONE: begin
          // abort and start are both ignored here; always return to idle
          state_reg <= S_IDLE;
        end

        default: begin
          // illegal encodings recover to idle with idle outputs
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.ld_en    = ld_en_reg;
  assign bus.it_en    = it_en_reg;
  assign bus.sub_sel  = sub_sel_reg;
  assign bus.fix_en   = fix_en_reg;
  assign bus.iter_idx = iter_idx_reg;
  // the sole combinational path: quotient bit follows the remainder sign
  assign bus.q_bit    = it_en_reg & ~bus.rem_neg;

endmodule

// File: tb/tb_sqrt_seq_ctrl.sv
// Directed testbench for sqrt_seq_ctrl at WIDTH=8 (four iterations).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_sqrt_seq_ctrl;
  localparam int WIDTH = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  sqrt_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

  sqrt_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one clock: past the rising edge to the next falling edge
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // full output vector {busy,done,ld_en,it_en,sub_sel,fix_en,q_bit,iter_idx[1:0]}
  task automatic chk_out(input string tag, input logic b, input logic d, input logic l,
                         input logic i, input logic s, input logic f, input logic q,
                         input logic [1:0] idx);
    logic [8:0] obs;
    logic [8:0] exp;
    obs = {bus.busy, bus.done, bus.ld_en, bus.it_en, bus.sub_sel, bus.fix_en,
           bus.q_bit, bus.iter_idx};
    exp = {b, d, l, i, s, f, q, idx};
    chk(tag, 16'(obs), 16'(exp));
    $display("step %-12s outs=%b exp=%b", tag, obs, exp);
  endtask

  // one complete request with rem_neg=0 throughout (no FIX step)
  task automatic run_nofix(input string tag);
    bus.rem_neg = 1'b0;
    bus.start   = 1'b1;
    cyc();
    bus.start = 1'b0;
    chk_out({tag, "_ld"}, 1, 0, 1, 0, 1, 0, 0, 2'd0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk_out({tag, "_it"}, 1, 0, 0, 1, 1, 0, 1, 2'(3 - i));
    end
    cyc();
    chk_out({tag, "_done"}, 0, 1, 0, 0, 1, 0, 0, 2'd0);
    cyc();
    chk_out({tag, "_idle"}, 0, 0, 0, 0, 1, 0, 0, 2'd0);
  endtask

  initial begin
    logic [3:0] pat;
    logic [3:0] exp_sub;
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.rem_neg = 1'b0;

    // reset state
    cyc();
    cyc();
    chk_out("reset", 0, 0, 0, 0, 1, 0, 0, 2'd0);
    rst_n = 1'b1;
    cyc();
    chk_out("post_rst", 0, 0, 0, 0, 1, 0, 0, 2'd0);

    // 1: basic sequence, no FIX
    run_nofix("t1");

    // 2: rem_neg 1,0,1,1 -> sub_sel 1,0,1,0, q_bit 0,1,0,0, then FIX
    pat     = 4'b1011;   // pat[3] is the first iteration
    exp_sub = 4'b1010;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    chk_out("t2_ld", 1, 0, 1, 0, 1, 0, 0, 2'd0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      bus.rem_neg = pat[3 - i];
      #1;
      chk_out("t2_it", 1, 0, 0, 1, exp_sub[3 - i], 0, ~pat[3 - i], 2'(3 - i));
    end
    cyc();
    bus.rem_neg = 1'b0;
    chk_out("t2_fix", 1, 0, 0, 0, 0, 1, 0, 2'd0);
    cyc();
    chk_out("t2_done", 0, 1, 0, 0, 1, 0, 0, 2'd0);
    cyc();
    chk_out("t2_idle", 0, 0, 0, 0, 1, 0, 0, 2'd0);

    // 3: start held high -> ld_en at cycles 1,8 and done at 6,13
    bus.start = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      cyc();
      chk("t3_ld", 16'(bus.ld_en), 16'((k == 1) || (k == 8)));
      chk("t3_done", 16'(bus.done), 16'((k == 6) || (k == 13)));
      $display("step t3 cycle %0d ld_en=%b done=%b busy=%b", k, bus.ld_en, bus.done, bus.busy);
    end
    bus.start = 1'b0;
    cyc();
    chk_out("t3_idle", 0, 0, 0, 0, 1, 0, 0, 2'd0);

    // 4: abort in cycle 3 (second ITER cycle)
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    cyc();
    cyc();
    chk_out("t4_it", 1, 0, 0, 1, 1, 0, 1, 2'd2);
    bus.abort = 1'b1;
    cyc();
    bus.abort = 1'b0;
    chk_out("t4_abort", 0, 0, 0, 0, 1, 0, 0, 2'd0);
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("t4_nodone", 16'({bus.done, bus.busy}), 16'd0);
    end
    run_nofix("t4_after");

    // 5: asynchronous reset mid-ITER
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    cyc();
    cyc();
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("t5_async", 0, 0, 0, 0, 1, 0, 0, 2'd0);
    cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 7; k++) begin
      cyc();
      chk("t5_nodone", 16'({bus.done, bus.busy}), 16'd0);
    end
    run_nofix("t5_after");

    // 6: start and abort together in IDLE -> nothing happens
    bus.start = 1'b1;
    bus.abort = 1'b1;
    cyc();
    chk_out("t6_both", 0, 0, 0, 0, 1, 0, 0, 2'd0);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    cyc();
    chk_out("t6_idle", 0, 0, 0, 0, 1, 0, 0, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
